osd_char_ram_arbiter: RTL and testbench

OSD_CHAR_RAM_ARBITER -- requirements
Module: osd_char_ram_arbiter

---
 rtl/osd_char_ram_arbiter_pkg.sv | 23 ++
 rtl/osd_char_ram_arbiter_if.sv | 35 +++
 rtl/osd_char_ram_arbiter_prio.sv | 52 +++++
 rtl/osd_char_ram_arbiter.sv | 159 +++++++++++++++
 tb/tb_osd_char_ram_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/osd_char_ram_arbiter_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// osd_arb_pkg : shared types and constants for the OSD char-RAM arbiter
// Rev 1.0
// ------------------------------------------------------------------
package osd_arb_pkg;

   localparam int ADDR_W_DEF = 11;
   localparam int DATA_W_DEF = 8;
   localparam logic [7:0] OVERRUN_MAX = 8'd255;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PEND = 2'd1,
      SWAP = 2'd2
   } swap_state_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      return (value == OVERRUN_MAX) ? value : value + 8'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/osd_char_ram_arbiter_if.sv
`default_nettype none
// ------------------------------------------------------------------
// osd_char_ram_arbiter_if : OSD and aux read-request/response bundle
// Rev 1.0
// ------------------------------------------------------------------
interface osd_char_ram_arbiter_if
   import osd_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);
   logic              osd_req;
   logic [ADDR_W-1:0] osd_addr;
   logic              osd_gnt;
   logic              osd_rvalid;
   logic [DATA_W-1:0] osd_rdata;

   logic              aux_req;
   logic [ADDR_W-1:0] aux_addr;
   logic              aux_gnt;
   logic              aux_rvalid;
   logic [DATA_W-1:0] aux_rdata;

   // master = the two readers, slave = the arbiter
   modport master (
      output osd_req, osd_addr, aux_req, aux_addr,
      input  osd_gnt, osd_rvalid, osd_rdata, aux_gnt, aux_rvalid, aux_rdata
   );

   modport slave (
      input  osd_req, osd_addr, aux_req, aux_addr,
      output osd_gnt, osd_rvalid, osd_rdata, aux_gnt, aux_rvalid, aux_rdata
   );
endinterface
`default_nettype wire

// File: rtl/osd_char_ram_arbiter_prio.sv
`default_nettype none
// ------------------------------------------------------------------
// osd_arb_prio : OSD-over-aux grant logic; optional aux starve guard
//                enabled by OSD_ARB_STARVE_GUARD_EN
// Rev 1.0
// ------------------------------------------------------------------
module osd_arb_prio
   import osd_arb_pkg::*;
#(
   parameter int STARVE_MAX = 15
)(
   input  wire logic video_clk,
   input  wire logic rst,
   input  wire logic osd_req,
   input  wire logic aux_req,
   output logic      osd_gnt,
   output logic      aux_gnt
);

   logic w_force_aux;

`ifdef OSD_ARB_STARVE_GUARD_EN
   localparam logic [3:0] c_starve_max = 4'(STARVE_MAX);

   logic [3:0] r_starve_cnt;

   assign w_force_aux = aux_req && (r_starve_cnt == c_starve_max);

   // counts cycles aux has been passed over; any aux grant resets it
   always_ff @(posedge video_clk) begin
      if (rst) begin
         r_starve_cnt <= 4'd0;
      end else if (aux_gnt) begin
         r_starve_cnt <= 4'd0;
      end else if (aux_req) begin
         r_starve_cnt <= r_starve_cnt + 4'd1;
      end
   end
`else
   logic w_unused;

   assign w_force_aux = 1'b0;
   assign w_unused    = &{1'b0, video_clk, rst, 1'(STARVE_MAX)};
`endif

   always_comb begin
      aux_gnt = aux_req && (!osd_req || w_force_aux);
      osd_gnt = osd_req && !aux_gnt;
   end

endmodule
`default_nettype wire

// File: rtl/osd_char_ram_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// osd_char_ram_arbiter : ping-pong char RAM read arbiter + bank swap FSM
//                        (aux starve guard: OSD_ARB_STARVE_GUARD_EN)
// Rev 1.0
// ------------------------------------------------------------------
module osd_char_ram_arbiter
   import osd_arb_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int STARVE_MAX = 15
)(
   input  wire logic              video_clk,
   input  wire logic              rst,
   input  wire logic              video_vsync,
   input  wire logic              udp_rec_data_valid,
   osd_char_ram_arbiter_if.slave  rd_bus,
   output logic [ADDR_W:0]        ram_rd_addr,
   input  wire logic [DATA_W-1:0] ram_rdata,
   output logic                   wr_bank,
   output logic                   pending,
   output logic [7:0]             overrun_cnt
);

   swap_state_t       r_state;
   swap_state_t       w_state_nxt;
   logic              w_bank_toggle;
   logic              w_overrun_inc;
   logic              r_wr_bank;
   logic              r_vsync_q;
   logic              r_vsync_rise;
   logic [7:0]        r_overrun;

   logic              w_osd_gnt;
   logic              w_aux_gnt;
   logic [ADDR_W:0]   r_rd_addr;
   logic              r_osd_v1;
   logic              r_aux_v1;
   logic              r_osd_v2;
   logic              r_aux_v2;
   logic [DATA_W-1:0] r_osd_hold;
   logic [DATA_W-1:0] r_aux_hold;

   osd_arb_prio #(
      .STARVE_MAX (STARVE_MAX)
   ) u_prio (
      .video_clk (video_clk),
      .rst       (rst),
      .osd_req   (rd_bus.osd_req),
      .aux_req   (rd_bus.aux_req),
      .osd_gnt   (w_osd_gnt),
      .aux_gnt   (w_aux_gnt)
   );

   // Two-stage owner pipeline matching the one-cycle address register
   // plus the RAM's one-cycle read latency.
   always_ff @(posedge video_clk) begin
      if (rst) begin
         r_rd_addr  <= '0;
         r_osd_v1   <= 1'b0;
         r_aux_v1   <= 1'b0;
         r_osd_v2   <= 1'b0;
         r_aux_v2   <= 1'b0;
         r_osd_hold <= '0;
         r_aux_hold <= '0;
      end else begin
         r_osd_v1 <= w_osd_gnt;
         r_aux_v1 <= w_aux_gnt;
         r_osd_v2 <= r_osd_v1;
         r_aux_v2 <= r_aux_v1;
         if (w_osd_gnt) begin
            r_rd_addr <= {~r_wr_bank, rd_bus.osd_addr};
         end else if (w_aux_gnt) begin
            r_rd_addr <= {~r_wr_bank, rd_bus.aux_addr};
         end
         if (r_osd_v2) begin
            r_osd_hold <= ram_rdata;
         end
         if (r_aux_v2) begin
            r_aux_hold <= ram_rdata;
         end
      end
   end

   assign rd_bus.osd_gnt    = w_osd_gnt;
   assign rd_bus.aux_gnt    = w_aux_gnt;
   assign rd_bus.osd_rvalid = r_osd_v2;
   assign rd_bus.aux_rvalid = r_aux_v2;
   assign rd_bus.osd_rdata  = r_osd_v2 ? ram_rdata : r_osd_hold;
   assign rd_bus.aux_rdata  = r_aux_v2 ? ram_rdata : r_aux_hold;
   assign ram_rd_addr       = r_rd_addr;

   always_ff @(posedge video_clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Banks flip on entry to SWAP, so only addresses registered from then on
   // see the new read bank.
   always_comb begin
      w_state_nxt   = r_state;
      w_bank_toggle = 1'b0;
      w_overrun_inc = 1'b0;
      case (r_state)
         IDLE: begin
            if (udp_rec_data_valid) begin
               if (r_vsync_rise) begin
                  w_state_nxt   = SWAP;
                  w_bank_toggle = 1'b1;
               end else begin
                  w_state_nxt = PEND;
               end
            end
         end
         PEND: begin
            w_overrun_inc = udp_rec_data_valid;
            if (r_vsync_rise) begin
               w_state_nxt   = SWAP;
               w_bank_toggle = 1'b1;
            end
         end
         SWAP: begin
            w_overrun_inc = udp_rec_data_valid;
            w_state_nxt   = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge video_clk) begin
      if (rst) begin
         r_wr_bank    <= 1'b0;
         r_vsync_q    <= 1'b0;
         r_vsync_rise <= 1'b0;
         r_overrun    <= 8'd0;
      end else begin
         r_vsync_q    <= video_vsync;
         r_vsync_rise <= video_vsync & ~r_vsync_q;
         if (w_bank_toggle) begin
            r_wr_bank <= ~r_wr_bank;
         end
         if (w_overrun_inc) begin
            r_overrun <= sat_inc8(r_overrun);
         end
      end
   end

   assign wr_bank     = r_wr_bank;
   assign pending     = (r_state == PEND);
   assign overrun_cnt = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_osd_char_ram_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_osd_char_ram_arbiter : directed + random self-check against a model
// Rev 1.0
// ------------------------------------------------------------------
module tb_osd_char_ram_arbiter;
   import osd_arb_pkg::*;

   localparam int ADDR_W     = 11;
   localparam int DATA_W     = 8;
   localparam int STARVE_MAX = 15;
   localparam int AW1        = ADDR_W + 1;
`ifdef OSD_ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic              video_clk = 1'b0;
   logic              rst = 1'b1;
   logic              video_vsync = 1'b0;
   logic              udp_rec_data_valid = 1'b0;
   logic [ADDR_W:0]   ram_rd_addr;
   logic [DATA_W-1:0] ram_rdata;
   logic              wr_bank;
   logic              pending;
   logic [7:0]        overrun_cnt;

   osd_char_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   osd_char_ram_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
   ) dut (
      .video_clk          (video_clk),
      .rst                (rst),
      .video_vsync        (video_vsync),
      .udp_rec_data_valid (udp_rec_data_valid),
      .rd_bus             (bus),
      .ram_rd_addr        (ram_rd_addr),
      .ram_rdata          (ram_rdata),
      .wr_bank            (wr_bank),
      .pending            (pending),
      .overrun_cnt        (overrun_cnt)
   );

   always #5 video_clk = ~video_clk;

   // RAM contents are a fixed function of {bank, addr}
   function automatic logic [7:0] ram_word(input logic [ADDR_W:0] a);
      return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h3C;
   endfunction

   logic [DATA_W-1:0] mem [0:(1<<AW1)-1];
   initial for (int i = 0; i < (1 << AW1); i++) mem[i] = ram_word(AW1'(i));
   always @(posedge video_clk) ram_rdata <= mem[ram_rd_addr];

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      bit              aux;
      logic [ADDR_W:0] a;
      int              due;
   } rd_t;

   rd_t               q[$];
   bit                chk_en = 1'b0;
   int                m_cyc = 0;
   int                m_wait = 0;
   int                m_ovr = 0;
   bit                m_bank = 1'b0;
   bit                m_pend = 1'b0;
   bit                m_swap = 1'b0;
   bit                m_vs_prev = 1'b0;
   bit                m_rise = 1'b0;
   logic [ADDR_W:0]   m_addr = '0;
   logic [DATA_W-1:0] m_osd_last = '0;
   logic [DATA_W-1:0] m_aux_last = '0;

   always @(negedge video_clk) if (chk_en) begin
      bit                e_ag, e_og, ov, av, busy, go, fresh;
      logic [DATA_W-1:0] e_od, e_ad;
      e_ag = bus.aux_req && (!bus.osd_req || (GUARD && m_wait == STARVE_MAX));
      e_og = bus.osd_req && !e_ag;
      ov = 1'b0; av = 1'b0; e_od = m_osd_last; e_ad = m_aux_last;
      if (q.size() > 0 && q[0].due == m_cyc) begin
         if (q[0].aux) begin av = 1'b1; e_ad = ram_word(q[0].a); end
         else          begin ov = 1'b1; e_od = ram_word(q[0].a); end
         void'(q.pop_front());
      end
      check("m_osd_gnt", bus.osd_gnt, e_og);
      check("m_aux_gnt", bus.aux_gnt, e_ag);
      check("m_rd_addr", ram_rd_addr, m_addr);
      check("m_osd_rvalid", bus.osd_rvalid, ov);
      check("m_aux_rvalid", bus.aux_rvalid, av);
      check("m_osd_rdata", bus.osd_rdata, e_od);
      check("m_aux_rdata", bus.aux_rdata, e_ad);
      check("m_wr_bank", wr_bank, m_bank);
      check("m_pending", pending, m_pend);
      check("m_overrun", overrun_cnt, m_ovr);
      if (rst) begin
         q.delete();
         m_wait = 0; m_ovr = 0; m_bank = 1'b0; m_pend = 1'b0; m_swap = 1'b0;
         m_vs_prev = 1'b0; m_rise = 1'b0; m_addr = '0;
         m_osd_last = '0; m_aux_last = '0;
      end else begin
         if (ov) m_osd_last = e_od;
         if (av) m_aux_last = e_ad;
         if (e_og || e_ag) begin
            m_addr = {~m_bank, e_og ? bus.osd_addr : bus.aux_addr};
            q.push_back('{e_ag, m_addr, m_cyc + 2});
         end
         if (e_ag) m_wait = 0;
         else if (bus.aux_req) m_wait++;
         // a packet arriving while one already waits (or swaps) is lost
         busy  = m_pend || m_swap;
         fresh = udp_rec_data_valid && !busy;
         if (udp_rec_data_valid && busy && m_ovr < 255) m_ovr++;
         go     = m_rise && (m_pend || fresh);
         m_pend = !go && (m_pend || fresh);
         m_swap = go;
         if (go) m_bank = !m_bank;
         m_rise    = video_vsync && !m_vs_prev;
         m_vs_prev = video_vsync;
      end
      m_cyc++;
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge video_clk);
      #1;
   endtask

   initial begin
      int first;
      int n;
      int osd_pct;
      bus.osd_req = 1'b0; bus.aux_req = 1'b0;
      bus.osd_addr = '0;  bus.aux_addr = '0;
      repeat (3) @(posedge video_clk);
      #1;
      chk_en = 1'b1;

      step(); rst = 1'b0; #3;
      check("rst_wr_bank", wr_bank, 0);
      check("rst_pending", pending, 0);
      check("rst_overrun", overrun_cnt, 0);
      check("rst_rd_addr", ram_rd_addr, 0);
      check("rst_osd_rvalid", bus.osd_rvalid, 0);
      check("rst_aux_rvalid", bus.aux_rvalid, 0);
      check("rst_osd_rdata", bus.osd_rdata, 0);
      check("rst_aux_rdata", bus.aux_rdata, 0);

      // OSD-only burst, addresses 0..3
      for (int c = 0; c < 8; c++) begin
         step();
         bus.osd_req  = (c < 4);
         bus.osd_addr = ADDR_W'(c);
         #3;
         if (c < 4) check("burst_osd_gnt", bus.osd_gnt, 1);
         if (c >= 1 && c <= 4) check("burst_rd_addr", ram_rd_addr, 12'h800 + c - 1);
         check("burst_osd_rvalid", bus.osd_rvalid, (c >= 2 && c <= 5));
         if (c == 2) check("burst_rdata0", bus.osd_rdata, 8'hB4);
         if (c >= 3 && c <= 5) check("burst_rdata", bus.osd_rdata, ram_word(12'h800 + AW1'(c - 2)));
      end

      // contention: both request for 20 cycles
      first = -1; n = 0;
      for (int c = 1; c <= 22; c++) begin
         step();
         bus.osd_req  = (c <= 20);
         bus.aux_req  = (c <= 20);
         bus.osd_addr = ADDR_W'($urandom);
         bus.aux_addr = ADDR_W'($urandom);
         #3;
         if (c <= 20 && bus.aux_gnt) begin
            n++;
            if (first < 0) first = c;
         end
      end
      check("first_aux_gnt", first, GUARD ? 16 : -1);
      check("aux_gnt_count", n, GUARD ? 1 : 0);

      // swap: packet, vsync rise 10 cycles later
      for (int c = 0; c <= 13; c++) begin
         step();
         udp_rec_data_valid = (c == 0);
         video_vsync        = (c >= 10);
         #3;
         if (c == 0) check("swap_pending_pre", pending, 0);
         if (c >= 1 && c <= 10) check("swap_pending_wait", pending, 1);
         if (c == 11) check("swap_wr_bank_before", wr_bank, 0);
         if (c == 12) begin
            check("swap_wr_bank_after", wr_bank, 1);
            check("swap_pending_after", pending, 0);
         end
      end

      // three packets before vsync
      for (int c = 0; c <= 13; c++) begin
         step();
         udp_rec_data_valid = (c == 0 || c == 2 || c == 4);
         video_vsync        = (c >= 8);
         #3;
         if (c == 9)  check("ovr3_bank_before", wr_bank, 1);
         if (c == 10) check("ovr3_bank_after", wr_bank, 0);
         if (c == 13) begin
            check("ovr3_count", overrun_cnt, 2);
            check("ovr3_single_swap", wr_bank, 0);
            check("ovr3_pending", pending, 0);
         end
      end

      // 300 packets before vsync saturate the overrun counter
      for (int c = 0; c < 305; c++) begin
         step();
         video_vsync        = 1'b0;
         udp_rec_data_valid = (c < 300);
         #3;
      end
      check("ovr300_count", overrun_cnt, 255);
      check("ovr300_pending", pending, 1);
      for (int c = 0; c <= 4; c++) begin
         step();
         udp_rec_data_valid = 1'b0;
         video_vsync        = (c >= 1);
         #3;
         if (c == 4) check("ovr300_swap_bank", wr_bank, 1);
      end

      // packet on the registered vsync edge from IDLE, reads straddling the toggle
      for (int c = 0; c <= 6; c++) begin
         step();
         video_vsync        = (c >= 2);
         udp_rec_data_valid = (c == 3);
         bus.osd_req        = (c == 3 || c == 4);
         bus.osd_addr       = 11'd5;
         #3;
         if (c == 3) begin
            check("sim_pending_c3", pending, 0);
            check("sim_bank_c3", wr_bank, 1);
         end
         if (c == 4) begin
            check("sim_bank_c4", wr_bank, 0);
            check("sim_pending_c4", pending, 0);
            check("sim_addr_old", ram_rd_addr, 12'h005);
         end
         if (c == 5) begin
            check("sim_addr_new", ram_rd_addr, 12'h805);
            check("sim_rvalid_old", bus.osd_rvalid, 1);
            check("sim_rdata_old", bus.osd_rdata, 8'h39);
         end
         if (c == 6) check("sim_rdata_new", bus.osd_rdata, 8'hB1);
      end

      // reset pulse during active reads
      for (int c = 0; c < 8; c++) begin
         step();
         rst          = (c == 3);
         bus.osd_req  = 1'b1;
         bus.aux_req  = (c % 3 == 0);
         bus.osd_addr = ADDR_W'($urandom);
         bus.aux_addr = ADDR_W'($urandom);
         #3;
         if (c == 4) begin
            check("rp_wr_bank", wr_bank, 0);
            check("rp_pending", pending, 0);
            check("rp_overrun", overrun_cnt, 0);
            check("rp_rd_addr", ram_rd_addr, 0);
            check("rp_osd_rvalid0", bus.osd_rvalid, 0);
            check("rp_aux_rvalid0", bus.aux_rvalid, 0);
            check("rp_osd_rdata", bus.osd_rdata, 0);
            check("rp_aux_rdata", bus.aux_rdata, 0);
         end
         if (c == 5) begin
            check("rp_osd_rvalid1", bus.osd_rvalid, 0);
            check("rp_aux_rvalid1", bus.aux_rvalid, 0);
         end
      end

      // randomized traffic, checked every cycle by the model
      for (int c = 0; c < 4000; c++) begin
         step();
         osd_pct            = ((c / 500) % 2 == 1) ? 90 : 40;
         rst                = ($urandom_range(0, 299) == 0);
         udp_rec_data_valid = ($urandom_range(0, 24) == 0);
         if ($urandom_range(0, 39) == 0) video_vsync = ~video_vsync;
         bus.osd_req  = ($urandom_range(0, 99) < osd_pct);
         bus.aux_req  = ($urandom_range(0, 99) < 50);
         bus.osd_addr = ADDR_W'($urandom);
         bus.aux_addr = ADDR_W'($urandom);
         #3;
      end

      step();
      rst = 1'b0; udp_rec_data_valid = 1'b0;
      bus.osd_req = 1'b0; bus.aux_req = 1'b0;
      repeat (4) step();
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
